// File: rtl/ahb3lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb3lite_pkg
// Description : Shared AHB3-Lite constants, hsize helper and APB bridge types.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [2:0] HSIZE_4WLINE  = 3'b100;
    localparam logic [2:0] HSIZE_8WLINE  = 3'b101;
    localparam logic [2:0] HSIZE_512     = 3'b110;
    localparam logic [2:0] HSIZE_1024    = 3'b111;

    localparam int HPROT_DATA       = 0;
    localparam int HPROT_PRIVILEGED = 1;
    localparam int HPROT_BUFFERABLE = 2;
    localparam int HPROT_CACHEABLE  = 3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int PPROT_PRIVILEGED  = 0;
    localparam int PPROT_NONSECURE   = 1;
    localparam int PPROT_INSTRUCTION = 2;

    typedef enum logic [2:0] {
        BR_IDLE   = 3'd0,
        BR_LATCH  = 3'd1,
        BR_SETUP  = 3'd2,
        BR_ACCESS = 3'd3,
        BR_ERR1   = 3'd4,
        BR_ERR2   = 3'd5
    } bridge_state_t;

    function automatic int hsize_bytes(input logic [2:0] hsize);
        return 1 << hsize;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb3lite_apb_lane.sv
`default_nettype none
// ============================================================================
// Module      : ahb3lite_apb_lane
// Description : Byte-lane steering between the AHB data bus and one APB beat.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb3lite_apb_lane
    import ahb3lite_pkg::*;
#(
    parameter int HDATA_SIZE = 32,
    parameter int PDATA_SIZE = 8,
    parameter int LAW        = (HDATA_SIZE > 8) ? $clog2(HDATA_SIZE / 8) : 1,
    parameter int OFFW       = (PDATA_SIZE > 8) ? $clog2(PDATA_SIZE / 8) : 1
)(
    input  logic [LAW-1:0]          beat_addr,
    input  logic [OFFW-1:0]         byte_off,
    input  logic [2:0]              size,
    input  logic                    write,
    input  logic [HDATA_SIZE-1:0]   hwdata,
    input  logic [PDATA_SIZE-1:0]   prdata,
    input  logic [HDATA_SIZE-1:0]   hrdata_cur,
    output logic [PDATA_SIZE-1:0]   pwdata,
    output logic [PDATA_SIZE/8-1:0] pstrb,
    output logic [HDATA_SIZE-1:0]   hrdata_next
);

    localparam int PB    = PDATA_SIZE / 8;
    localparam int HB    = HDATA_SIZE / 8;
    localparam int NLANE = HB / PB;
    localparam int PBL   = $clog2(PB);
    localparam int HBL   = $clog2(HB);
    localparam int SW    = (NLANE > 1) ? $clog2(NLANE) : 1;

    logic [SW-1:0] w_sel;
    int            w_tb;
    logic          w_unused_ok;

    generate
        if (NLANE > 1) begin : g_multi
            assign w_sel = beat_addr[HBL-1:PBL];
        end else begin : g_single
            assign w_sel = '0;
        end
    endgenerate

    always_comb begin
        pwdata      = '0;
        hrdata_next = hrdata_cur;
        for (int l = 0; l < NLANE; l++) begin
            if (w_sel == SW'(l)) begin
                pwdata = write ? hwdata[l*PDATA_SIZE +: PDATA_SIZE] : '0;
                hrdata_next[l*PDATA_SIZE +: PDATA_SIZE] = prdata;
            end
        end
    end

    // Sub-lane transfers strobe only their own bytes; wider ones fill the lane.
    always_comb begin
        w_tb  = hsize_bytes(size);
        pstrb = '0;
        for (int i = 0; i < PB; i++) begin
            if (write) begin
                if (w_tb >= PB) pstrb[i] = 1'b1;
                else            pstrb[i] = (i >= int'(byte_off)) && (i < int'(byte_off) + w_tb);
            end
        end
    end

    assign w_unused_ok = &{1'b0, beat_addr};

endmodule
`default_nettype wire

// File: rtl/ahb3lite_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb3lite_apb_bridge
// Description : AHB3-Lite slave to APB4 master bridge with width conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb3lite_apb_bridge
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 8
)(
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [HADDR_SIZE-1:0]   HADDR,
    input  logic [HDATA_SIZE-1:0]   HWDATA,
    output logic [HDATA_SIZE-1:0]   HRDATA,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic [1:0]              HTRANS,
    input  logic                    HMASTLOCK,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [2:0]              PPROT,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int PB   = PDATA_SIZE / 8;
    localparam int HB   = HDATA_SIZE / 8;
    localparam int PBL  = $clog2(PB);
    localparam int HBL  = $clog2(HB);
    localparam int BW   = HBL - PBL + 1;
    localparam int LAW  = (HBL > 0) ? HBL : 1;
    localparam int OFFW = (PBL > 0) ? PBL : 1;

    bridge_state_t           r_state;
    logic [HADDR_SIZE-1:0]   r_addr;
    logic [2:0]              r_size;
    logic                    r_write;
    logic [3:0]              r_prot;
    logic [HDATA_SIZE-1:0]   r_hwdata;
    logic [BW-1:0]           r_beat;

    logic                    w_accept;
    logic                    w_illegal;
    logic [BW-1:0]           w_last_beat;
    logic                    w_is_last;
    logic [BW-1:0]           w_next_beat;
    logic [HADDR_SIZE-1:0]   w_base;
    logic [HADDR_SIZE-1:0]   w_next_addr;
    logic [HADDR_SIZE-1:0]   w_cur_addr;
    logic [HADDR_SIZE-1:0]   w_lane_addr;
    logic [HDATA_SIZE-1:0]   w_wsrc;
    logic [PDATA_SIZE-1:0]   w_pwdata;
    logic [PDATA_SIZE/8-1:0] w_pstrb;
    logic [HDATA_SIZE-1:0]   w_hrdata_next;
    logic [2:0]              w_pprot;
    logic                    w_unused_ok;

    assign w_accept  = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign w_illegal = (r_size > 3'(HBL));

    always_comb begin
        w_last_beat = '0;
        if (r_size > 3'(PBL)) w_last_beat = BW'((1 << (r_size - 3'(PBL))) - 1);
    end

    assign w_is_last   = (r_beat == w_last_beat);
    assign w_next_beat = (r_state == BR_ACCESS) ? r_beat + BW'(1) : '0;
    assign w_base      = r_addr & ~HADDR_SIZE'(PB - 1);
    assign w_next_addr = w_base + (HADDR_SIZE'(w_next_beat) << PBL);
    assign w_cur_addr  = w_base + (HADDR_SIZE'(r_beat) << PBL);

    // One lane instance serves both directions: a completing read beat needs
    // its own lane, a write needs the lane of the beat being set up next.
    assign w_lane_addr = ((r_state == BR_ACCESS) && !r_write) ? w_cur_addr : w_next_addr;
    assign w_wsrc      = (r_state == BR_LATCH) ? HWDATA : r_hwdata;

    always_comb begin
        w_pprot                    = '0;
        w_pprot[PPROT_PRIVILEGED]  = r_prot[HPROT_PRIVILEGED];
        w_pprot[PPROT_INSTRUCTION] = ~r_prot[HPROT_DATA];
    end

    ahb3lite_apb_lane #(
        .HDATA_SIZE (HDATA_SIZE),
        .PDATA_SIZE (PDATA_SIZE),
        .LAW        (LAW),
        .OFFW       (OFFW)
    ) u_lane (
        .beat_addr   (w_lane_addr[LAW-1:0]),
        .byte_off    (r_addr[OFFW-1:0]),
        .size        (r_size),
        .write       (r_write),
        .hwdata      (w_wsrc),
        .prdata      (PRDATA),
        .hrdata_cur  (HRDATA),
        .pwdata      (w_pwdata),
        .pstrb       (w_pstrb),
        .hrdata_next (w_hrdata_next)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= BR_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PWRITE    <= 1'b0;
            PPROT     <= '0;
            r_addr    <= '0;
            r_size    <= '0;
            r_write   <= 1'b0;
            r_prot    <= '0;
            r_hwdata  <= '0;
            r_beat    <= '0;
        end else begin
            case (r_state)
                BR_IDLE: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    if (w_accept) begin
                        r_addr    <= HADDR;
                        r_size    <= HSIZE;
                        r_write   <= HWRITE;
                        r_prot    <= HPROT;
                        r_beat    <= '0;
                        HREADYOUT <= 1'b0;
                        r_state   <= BR_LATCH;
                    end
                end
                BR_LATCH: begin
                    r_hwdata <= HWDATA;
                    if (w_illegal) begin
                        HRESP   <= HRESP_ERROR;
                        r_state <= BR_ERR1;
                    end else begin
                        PADDR   <= w_next_addr[PADDR_SIZE-1:0];
                        PWDATA  <= w_pwdata;
                        PSTRB   <= w_pstrb;
                        PWRITE  <= r_write;
                        PPROT   <= w_pprot;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        r_state <= BR_SETUP;
                    end
                end
                BR_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= BR_ACCESS;
                end
                BR_ACCESS: begin
                    if (PREADY) begin
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            PSEL    <= 1'b0;
                            HRESP   <= HRESP_ERROR;
                            r_state <= BR_ERR1;
                        end else begin
                            if (!r_write) HRDATA <= w_hrdata_next;
                            if (w_is_last) begin
                                PSEL      <= 1'b0;
                                HREADYOUT <= 1'b1;
                                r_state   <= BR_IDLE;
                            end else begin
                                r_beat  <= w_next_beat;
                                PADDR   <= w_next_addr[PADDR_SIZE-1:0];
                                PWDATA  <= w_pwdata;
                                PSTRB   <= w_pstrb;
                                r_state <= BR_SETUP;
                            end
                        end
                    end
                end
                BR_ERR1: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                    r_state   <= BR_ERR2;
                end
                BR_ERR2: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    r_state   <= BR_IDLE;
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    r_state   <= BR_IDLE;
                end
            endcase
        end
    end

    assign w_unused_ok = &{1'b0, HBURST, HMASTLOCK, r_prot, w_next_addr, w_cur_addr, w_lane_addr};

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb3lite_apb_bridge
// Description : Directed bench for the bridge on 32->8 and 32->32 configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb3lite_apb_bridge;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        sel8, sel32, use32;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock, pready, pslverr;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hready;

    logic [31:0] hrdata8, hrdata32, pwdata32;
    logic        ho8, ho32, hresp8, hresp32, psel8, psel32, pen8, pen32, pwrite8, pwrite32;
    logic [2:0]  pprot8, pprot32;
    logic [9:0]  paddr8, paddr32;
    logic [0:0]  pstrb8;
    logic [3:0]  pstrb32;
    logic [7:0]  pwdata8, prdata8;
    logic [31:0] prdata32;

    logic        m_ho, m_resp, m_psel, m_pen, m_pwrite;
    logic [9:0]  m_paddr;
    logic [31:0] m_pwdata, m_hrdata;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;

    int checks = 0;
    int failures = 0;
    int waits, nbeats;
    logic low_resp, exit_resp, unstable;
    logic [9:0]  b_addr  [8];
    logic [31:0] b_wdata [8];
    logic [3:0]  b_strb  [8];
    logic [2:0]  b_prot  [8];
    logic        b_write [8];

    always #5 hclk = ~hclk;
    assign hready = use32 ? ho32 : ho8;

    always_comb begin
        if (use32) begin
            m_ho = ho32; m_resp = hresp32; m_psel = psel32; m_pen = pen32; m_pwrite = pwrite32;
            m_paddr = paddr32; m_pwdata = pwdata32; m_hrdata = hrdata32; m_pstrb = pstrb32; m_pprot = pprot32;
        end else begin
            m_ho = ho8; m_resp = hresp8; m_psel = psel8; m_pen = pen8; m_pwrite = pwrite8;
            m_paddr = paddr8; m_pwdata = {24'h0, pwdata8}; m_hrdata = hrdata8; m_pstrb = {3'b000, pstrb8};
            m_pprot = pprot8;
        end
    end

    ahb3lite_apb_bridge #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(10), .PDATA_SIZE(8)) dut8 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(sel8), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata8),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ho8), .HRESP(hresp8), .PSEL(psel8),
        .PENABLE(pen8), .PPROT(pprot8), .PADDR(paddr8), .PWRITE(pwrite8), .PSTRB(pstrb8),
        .PWDATA(pwdata8), .PRDATA(prdata8), .PREADY(pready), .PSLVERR(pslverr)
    );

    ahb3lite_apb_bridge #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(10), .PDATA_SIZE(32)) dut32 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(sel32), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata32),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ho32), .HRESP(hresp32), .PSEL(psel32),
        .PENABLE(pen32), .PPROT(pprot32), .PADDR(paddr32), .PWRITE(pwrite32), .PSTRB(pstrb32),
        .PWDATA(pwdata32), .PRDATA(prdata32), .PREADY(pready), .PSLVERR(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one AHB transfer and plays a zero-wait APB slave, recording each completed beat.
    task automatic run_xfer(input bit s32, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                            input logic [3:0] prot, input logic [31:0] wdata, input logic [31:0] rbase,
                            input int stall_beat, input int stall_n, input int err_beat);
        logic [9:0]  sa;
        logic [31:0] sw;
        bit          seen;
        int          stalled;
        use32 = s32;
        @(negedge hclk);
        sel8 = !s32; sel32 = s32; haddr = addr; hwrite = wr; hsize = size; hprot = prot; htrans = 2'b10;
        @(negedge hclk);
        sel8 = 1'b0; sel32 = 1'b0; htrans = 2'b00; hwdata = wdata;
        waits = 0; nbeats = 0; unstable = 1'b0; low_resp = 1'b0; stalled = 0; seen = 1'b0;
        sa = '0; sw = '0;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge hclk);
            exit_resp = m_resp;
            if (m_ho) break;
            waits++;
            low_resp = m_resp;
            pready = 1'b1; pslverr = 1'b0;
            if (m_psel && m_pen) begin
                if (seen && (m_paddr !== sa || m_pwdata !== sw)) unstable = 1'b1;
                if (nbeats == stall_beat && stalled < stall_n) begin
                    if (!seen) begin sa = m_paddr; sw = m_pwdata; seen = 1'b1; end
                    pready = 1'b0;
                    stalled++;
                end else begin
                    if (nbeats < 8) begin
                        b_addr[nbeats] = m_paddr; b_wdata[nbeats] = m_pwdata; b_strb[nbeats] = m_pstrb;
                        b_prot[nbeats] = m_pprot; b_write[nbeats] = m_pwrite;
                    end
                    prdata8  = rbase[7:0] + 8'(nbeats);
                    prdata32 = rbase;
                    pslverr  = (nbeats == err_beat);
                    nbeats++;
                    seen = 1'b0;
                end
            end
        end
        pready = 1'b1; pslverr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        hresetn = 1'b0; sel8 = 1'b0; sel32 = 1'b0; use32 = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
        hsize = '0; hburst = '0; hprot = '0; htrans = 2'b00; hmastlock = 1'b0; pready = 1'b1;
        pslverr = 1'b0; prdata8 = '0; prdata32 = '0;
        repeat (3) @(negedge hclk);
        chk("rst_hreadyout", 64'(m_ho), 64'h1);
        chk("rst_hresp", 64'(m_resp), 64'h0);
        chk("rst_hrdata", 64'(m_hrdata), 64'h0);
        chk("rst_psel_penable", 64'({m_psel, m_pen, m_pwrite}), 64'h0);
        chk("rst_paddr_pwdata", 64'({m_paddr, m_pwdata[7:0], m_pstrb, m_pprot}), 64'h0);
        hresetn = 1'b1;

        // Word write over 8-bit APB: four byte beats, little-endian lane order.
        run_xfer(1'b0, 32'h104, 1'b1, 3'd2, 4'b0011, 32'h11223344, 32'h0, -1, 0, -1);
        chk("w32_waits", 64'(waits), 64'd9);
        chk("w32_beats", 64'(nbeats), 64'd4);
        chk("w32_hresp", 64'(exit_resp), 64'h0);
        chk("w32_b0", 64'({b_addr[0], b_wdata[0], b_strb[0]}), 64'({10'h104, 32'h44, 4'h1}));
        chk("w32_b1", 64'({b_addr[1], b_wdata[1], b_strb[1]}), 64'({10'h105, 32'h33, 4'h1}));
        chk("w32_b2", 64'({b_addr[2], b_wdata[2], b_strb[2]}), 64'({10'h106, 32'h22, 4'h1}));
        chk("w32_b3", 64'({b_addr[3], b_wdata[3], b_strb[3]}), 64'({10'h107, 32'h11, 4'h1}));
        chk("w32_pprot_pwrite", 64'({b_prot[0], b_write[0]}), 64'({3'b001, 1'b1}));

        // Halfword read on 32-bit APB: aligned PADDR, whole PRDATA lands on HRDATA.
        run_xfer(1'b1, 32'h202, 1'b0, 3'd1, 4'b0000, 32'h0, 32'hAABBCCDD, -1, 0, -1);
        chk("rh_waits", 64'(waits), 64'd3);
        chk("rh_beats", 64'(nbeats), 64'd1);
        chk("rh_paddr", 64'(b_addr[0]), 64'h200);
        chk("rh_pstrb_pwrite", 64'({b_strb[0], b_write[0]}), 64'h0);
        chk("rh_pprot", 64'(b_prot[0]), 64'h4);
        chk("rh_hrdata", 64'(m_hrdata), 64'hAABBCCDD);

        // Byte write at offset 3 on 32-bit APB.
        run_xfer(1'b1, 32'h003, 1'b1, 3'd0, 4'b0001, 32'h5A000000, 32'h0, -1, 0, -1);
        chk("wb_waits", 64'(waits), 64'd3);
        chk("wb_pstrb", 64'(b_strb[0]), 64'h8);
        chk("wb_pwdata", 64'(b_wdata[0]), 64'h5A000000);
        chk("wb_paddr", 64'(b_addr[0]), 64'h000);
        chk("wb_hrdata_held", 64'(m_hrdata), 64'hAABBCCDD);

        // PSLVERR on the second of four beats.
        run_xfer(1'b0, 32'h040, 1'b1, 3'd2, 4'b0001, 32'hCAFEF00D, 32'h0, -1, 0, 1);
        chk("err_beats", 64'(nbeats), 64'd2);
        chk("err_waits", 64'(waits), 64'd6);
        chk("err_low_resp", 64'(low_resp), 64'h1);
        chk("err_ready_resp", 64'(exit_resp), 64'h1);
        @(negedge hclk);
        chk("err_back_idle", 64'({m_ho, m_resp, m_psel}), 64'({1'b1, 1'b0, 1'b0}));

        // PREADY stall on the first beat stretches the data phase by three cycles.
        run_xfer(1'b0, 32'h010, 1'b1, 3'd2, 4'b0001, 32'hDEADBEEF, 32'h0, 0, 3, -1);
        chk("stall_waits", 64'(waits), 64'd12);
        chk("stall_beats", 64'(nbeats), 64'd4);
        chk("stall_stable", 64'(unstable), 64'h0);
        chk("stall_b0", 64'({b_addr[0], b_wdata[0]}), 64'({10'h010, 32'hEF}));
        chk("stall_b3", 64'({b_addr[3], b_wdata[3]}), 64'({10'h013, 32'hDE}));

        // Word read over 8-bit APB: beats reassembled into their lanes.
        run_xfer(1'b0, 32'h020, 1'b0, 3'd2, 4'b0001, 32'h0, 32'hA0, -1, 0, -1);
        chk("r32_waits", 64'(waits), 64'd9);
        chk("r32_hrdata", 64'(m_hrdata), 64'hA3A2A1A0);
        chk("r32_b2", 64'({b_addr[2], b_strb[2]}), 64'({10'h022, 4'h0}));

        // Doubleword on a 32-bit AHB bus is illegal: error without APB access.
        run_xfer(1'b0, 32'h000, 1'b1, 3'd3, 4'b0001, 32'h0, 32'h0, -1, 0, -1);
        chk("ill_beats", 64'(nbeats), 64'd0);
        chk("ill_waits", 64'(waits), 64'd2);
        chk("ill_resp", 64'({low_resp, exit_resp}), 64'h3);
        @(negedge hclk);

        // Zero-wait OKAY for an IDLE transfer.
        use32 = 1'b0; sel8 = 1'b1; htrans = 2'b00; haddr = 32'h100; hwrite = 1'b1;
        @(negedge hclk);
        chk("idle_xfer", 64'({m_ho, m_resp, m_psel}), 64'({1'b1, 1'b0, 1'b0}));
        sel8 = 1'b0;

        // Asynchronous reset while the bridge sits in ACCESS.
        @(negedge hclk);
        sel8 = 1'b1; haddr = 32'h080; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(negedge hclk);
        sel8 = 1'b0; htrans = 2'b00; hwdata = 32'h01020304;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (m_psel && m_pen) begin found = 1'b1; break; end
            @(negedge hclk);
        end
        chk("rst_reach_access", 64'(found), 64'h1);
        pready = 1'b0;
        hresetn = 1'b0;
        #1;
        chk("arst_apb", 64'({m_psel, m_pen}), 64'h0);
        chk("arst_ahb", 64'({m_ho, m_resp}), 64'({1'b1, 1'b0}));
        @(negedge hclk);
        hresetn = 1'b1; pready = 1'b1;
        sel8 = 1'b1; htrans = 2'b00;
        @(negedge hclk);
        chk("arst_idle_xfer", 64'({m_ho, m_resp, m_psel}), 64'({1'b1, 1'b0, 1'b0}));
        sel8 = 1'b0;
        @(negedge hclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb3lite_apb_bridge.md
Name: ahb3lite_apb_bridge

Overview:
Parametrised AHB3-Lite slave to APB4 master bridge on a single clock domain. It converts each AHB transfer into one or more APB transfers. When the AHB transfer is wider than PDATA_SIZE, it is split into sequential APB beats; write data is lane-selected, and read data is re-assembled onto HRDATA. It sits between the AHB interconnect and a peripheral APB segment. It adds width conversion, PSTRB generation and PSLVERR-to-HRESP error mapping.

Parameters:
HADDR_SIZE, 32, AHB address width
HDATA_SIZE, 32, AHB data width; power of 2, >= PDATA_SIZE
PADDR_SIZE, 10, APB address width; <= HADDR_SIZE
PDATA_SIZE, 8, APB data width; power of 2, 8..HDATA_SIZE

Ports:
HCLK  in  1  clock, shared by AHB and APB sides
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  address
HWDATA  in  HDATA_SIZE  write data (data phase)
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  write=1
HSIZE  in  3  transfer size
HBURST  in  3  burst type (ignored; each beat handled as independent transfer)
HPROT  in  4  protection
HTRANS  in  2  transfer type
HMASTLOCK  in  1  ignored
HREADY  in  1  system ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PPROT  out  3  APB protection
PADDR  out  PADDR_SIZE  APB address
PWRITE  out  1  APB direction
PSTRB  out  PDATA_SIZE/8  write strobes
PWDATA  out  PDATA_SIZE  APB write data
PRDATA  in  PDATA_SIZE  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset values (asynchronous, HRESETn=0):
  - State returns to IDLE immediately.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PSTRB=0, PWRITE=0, PPROT=0.
- Reset mid-transfer aborts the transfer; no APB completion is required.
- Accept condition: HSEL & HREADY & HTRANS in {NONSEQ,SEQ}, state IDLE. On accept, capture HADDR, HSIZE, HWRITE, HPROT.
- HSEL & HREADY & HTRANS in {IDLE,BUSY}: zero-wait OKAY, no APB activity.
- Size and beat rules:
  - Define PB = PDATA_SIZE/8 and TB = 1<<HSIZE.
  - beats = max(1, TB/PB).
  - TB > HDATA_SIZE/8 is illegal and gets an ERROR response with no APB access.
- Beat k address: PADDR = ((HADDR & ~(PB-1)) + k*PB) truncated to PADDR_SIZE. Wrap above PADDR_SIZE is silent truncation.
- PPROT = {~HPROT[0], 1'b0, HPROT[1]}.
- Write data and strobes:
  - PWDATA = HDATA byte lane of HWDATA_reg selected by beat address.
  - PSTRB, when TB >= PB: all ones.
  - PSTRB, when TB < PB: ones only for bytes [HADDR%PB +: TB].
- Reads: PSTRB=0. Beat k PRDATA is written into HRDATA at the lane of its address. Untouched lanes keep their previous value. HRDATA is held until the next read completes.
- FSM states: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On accept -> LATCH.
  - LATCH: HREADYOUT=0; register HWDATA. Illegal size -> ERR1; otherwise -> SETUP.
  - SETUP: PSEL=1, PENABLE=0 -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; PADDR, PWDATA, PSTRB, PWRITE, PPROT held stable while PREADY=0.
  - ACCESS, PREADY & PSLVERR -> ERR1; remaining beats are dropped.
  - ACCESS, PREADY & ~PSLVERR & more beats -> SETUP with k+1.
  - ACCESS, PREADY & ~PSLVERR & last beat -> IDLE.
  - PSLVERR is ignored when PREADY=0.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE. A new address phase presented in ERR2 is not accepted; the master must cancel it per AHB error rules.
- Latency with zero-wait APB: the data phase lasts 1 + 2*beats + 1 cycles, with HREADYOUT low for 2*beats+1 cycles. Example: 32-bit over 8-bit APB = 9 wait cycles.
- PSEL and PENABLE return low in IDLE: no back-to-back APB transfers without a SETUP.

Decomposition:
- Shared package ahb3lite_pkg (existing) supplies the HTRANS, HSIZE, HPROT and HRESP constants and the hsize-to-bytes helper.
- Add to the package: a bridge state enum typedef, and an APB PPROT bit constants group (PPROT_PRIVILEGED, PPROT_NONSECURE, PPROT_INSTRUCTION).
- One combinational sub-module, ahb3lite_apb_lane: given beat address, size, HWDATA_reg and PRDATA, it produces PWDATA, PSTRB and the HRDATA lane update.

Test Plan:
- HDATA=32, PDATA=8, zero-wait APB, write word 0x11223344 to 0x104:
  - PADDR 0x104..0x107 carry PWDATA 0x44, 0x33, 0x22, 0x11 with PSTRB=1.
  - HREADYOUT is low 9 cycles; HRESP=OKAY.
- HDATA=32, PDATA=32, read halfword from 0x202, PRDATA=0xAABBCCDD: one APB beat at PADDR 0x200, PSTRB=0, HRDATA=0xAABBCCDD.
- HDATA=32, PDATA=32, write byte 0x5A to 0x03 with HWDATA=0x5A000000: PSTRB=4'b1000, PWDATA=0x5A000000.
- 4-beat write with PSLVERR=1 on beat 2: beats 3-4 are not issued; HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE.
- PREADY held low 3 cycles on beat 1: the ACCESS phase is extended by 3 cycles with PADDR and PWDATA stable; total wait equals 9+3.
- Assert HRESETn=0 during ACCESS: PSEL, PENABLE and HRESP go 0 and HREADYOUT goes 1 immediately. Then HSEL with HTRANS=IDLE gives a zero-wait OKAY.
